// File: rtl/des_crack_pkg.sv
// rtl/des_crack_pkg.sv - shared widths and search FSM states for the DES key-search controller
package des_crack_pkg;

  localparam int KEY_W_DEF = 56;
  localparam int BLK_W_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } search_state_t;

endpackage

// File: rtl/des_ct_match.sv
// rtl/des_ct_match.sv - registered ciphertext/target equality flag, updated on each accepted DES result
module des_ct_match #(
  parameter int BLK_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [BLK_W-1:0] ct,
  input  logic [BLK_W-1:0] target,
  output logic             match
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match <= 1'b0;
    end else if (clr) begin
      match <= 1'b0;
    end else if (en) begin
      match <= (ct == target);
    end
  end

endmodule

// File: rtl/des_key_search_ctrl.sv
// rtl/des_key_search_ctrl.sv - steps the key counter, launches DES per candidate and compares each result with the target
module des_key_search_ctrl
  import des_crack_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int BLK_W = BLK_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] start_key,
  input  logic [KEY_W-1:0] end_key,
  input  logic [BLK_W-1:0] target_ct,
  output logic             cnt_load,
  output logic             cnt_up,
  output logic [KEY_W-1:0] cnt_in,
  input  logic [KEY_W-1:0] cnt_val,
  output logic             des_start,
  output logic [KEY_W-1:0] des_key,
  input  logic             des_done,
  input  logic [BLK_W-1:0] des_ct,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W-1:0] found_key,
  output logic [KEY_W:0]   trials
);

  search_state_t    state, state_nx;
  logic [KEY_W-1:0] start_q, end_q;
  logic [BLK_W-1:0] target_q;
  logic             match;
  logic             accept;
  logic             last_key;

  assign accept   = ((state == S_IDLE) || (state == S_DONE)) && start && !abort;
  assign last_key = (des_key == end_q);
  assign cnt_in   = start_q;

  des_ct_match #(.BLK_W(BLK_W)) u_match (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept || abort),
    .en     ((state == S_WAIT) && des_done && !abort),
    .ct     (des_ct),
    .target (target_q),
    .match  (match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_nx = S_LOAD;
        S_LOAD:         state_nx = S_LAUNCH;
        S_LAUNCH:       state_nx = S_WAIT;
        S_WAIT:         if (des_done) state_nx = S_CHECK;
        S_CHECK:        state_nx = (match || last_key) ? S_DONE : S_LAUNCH;
        default:        state_nx = S_IDLE;
      endcase
    end
  end

  // Strobes are gated by abort so a cancelled cycle never moves the counter or launches DES.
  always_comb begin
    busy      = 1'b0;
    cnt_load  = 1'b0;
    cnt_up    = 1'b0;
    des_start = 1'b0;
    case (state)
      S_LOAD: begin
        busy     = 1'b1;
        cnt_load = !abort;
      end
      S_LAUNCH: begin
        busy      = 1'b1;
        des_start = !abort;
      end
      S_WAIT:  busy = 1'b1;
      S_CHECK: begin
        busy   = 1'b1;
        cnt_up = !abort && !match && !last_key;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q   <= '0;
      end_q     <= '0;
      target_q  <= '0;
      des_key   <= '0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      found_key <= '0;
      trials    <= '0;
    end else if (abort) begin
      found     <= 1'b0;
      exhausted <= 1'b0;
      found_key <= '0;
      trials    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            start_q   <= start_key;
            end_q     <= end_key;
            target_q  <= target_ct;
            found     <= 1'b0;
            exhausted <= 1'b0;
            found_key <= '0;
            trials    <= '0;
          end
        end
        S_LAUNCH: des_key <= cnt_val;
        S_WAIT:   if (des_done) trials <= trials + (KEY_W+1)'(1);
        S_CHECK: begin
          if (match) begin
            found     <= 1'b1;
            found_key <= des_key;
          end else if (last_key) begin
            exhausted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_search_ctrl.sv
// tb/tb_des_key_search_ctrl.sv - directed bench with falling-edge counter model and 4-cycle DES stub
module tb_des_key_search_ctrl;

  localparam int KW = 8;
  localparam int BW = 64;
  localparam logic [BW-1:0] NO_CT = 64'hFFFF_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] start_key = '0;
  logic [KW-1:0] end_key = '0;
  logic [BW-1:0] target_ct = '0;
  logic          cnt_load, cnt_up, des_start, busy, found, exhausted;
  logic [KW-1:0] cnt_in, des_key, found_key;
  logic [KW-1:0] cnt_val = '0;
  logic          des_done = 1'b0;
  logic [BW-1:0] des_ct = '0;
  logic [KW:0]   trials;

  int ncmp = 0;
  int nfail = 0;
  int n_start = 0;
  int n_up = 0;
  int n_log = 0;
  int cd = 0;
  logic [KW-1:0] keylog [0:255];
  int s0, u0, l0;

  des_key_search_ctrl #(.KEY_W(KW), .BLK_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .start_key (start_key),
    .end_key   (end_key),
    .target_ct (target_ct),
    .cnt_load  (cnt_load),
    .cnt_up    (cnt_up),
    .cnt_in    (cnt_in),
    .cnt_val   (cnt_val),
    .des_start (des_start),
    .des_key   (des_key),
    .des_done  (des_done),
    .des_ct    (des_ct),
    .busy      (busy),
    .found     (found),
    .exhausted (exhausted),
    .found_key (found_key),
    .trials    (trials)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_load)    cnt_val <= cnt_in;
    else if (cnt_up) cnt_val <= cnt_val + 8'd1;
  end

  // DES stub: launch in cycle N gives des_done in cycle N+4
  always @(posedge clk) begin
    des_done <= 1'b0;
    if (des_start) begin
      cd <= 3;
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        des_done <= 1'b1;
        des_ct   <= {56'h0, des_key ^ 8'hA5};
      end
    end
  end

  always @(posedge clk) begin
    if (des_start) n_start = n_start + 1;
    if (cnt_up)    n_up = n_up + 1;
    if (des_done && busy) begin
      keylog[n_log % 256] = des_key;
      n_log = n_log + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [KW-1:0] sk, input logic [KW-1:0] ek, input logic [BW-1:0] tc);
    @(posedge clk); #1;
    start = 1'b1; start_key = sk; end_key = ek; target_ct = tc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (found || exhausted) break;
    end
    check("done_seen", 64'(found | exhausted), 64'd1);
  endtask

  task automatic wait_trials(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (trials == (KW+1)'(n)) break;
    end
    check("trials_reach", 64'(trials), 64'(n));
  endtask

  initial begin
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_found", 64'(found), 64'd0);
    check("rst_exh", 64'(exhausted), 64'd0);
    check("rst_trials", 64'(trials), 64'd0);
    check("rst_strobes", 64'({des_start, cnt_load, cnt_up}), 64'd0);
    check("rst_key", 64'({des_key, found_key, cnt_in}), 64'd0);
    @(negedge clk); rst = 1'b1;

    // match in the middle of the range
    s0 = n_start; u0 = n_up;
    kick(8'h10, 8'h20, {56'h0, 8'h17 ^ 8'hA5});
    wait_done();
    check("s1_found", 64'(found), 64'd1);
    check("s1_fkey", 64'(found_key), 64'h17);
    check("s1_exh", 64'(exhausted), 64'd0);
    check("s1_trials", 64'(trials), 64'd8);
    check("s1_launches", 64'(n_start - s0), 64'd8);
    check("s1_ups", 64'(n_up - u0), 64'd7);

    // no match, with a start issued mid-search that must not relatch
    u0 = n_up;
    kick(8'h30, 8'h33, NO_CT);
    repeat (5) @(posedge clk);
    kick(8'h00, 8'h01, {56'h0, 8'h00 ^ 8'hA5});
    wait_done();
    check("s2_exh", 64'(exhausted), 64'd1);
    check("s2_found", 64'(found), 64'd0);
    check("s2_trials", 64'(trials), 64'd4);
    check("s2_lastkey", 64'(des_key), 64'h33);
    check("s2_ups", 64'(n_up - u0), 64'd3);

    // wrap through zero
    l0 = n_log;
    kick(8'hFE, 8'h01, NO_CT);
    wait_done();
    check("s3_exh", 64'(exhausted), 64'd1);
    check("s3_trials", 64'(trials), 64'd4);
    check("s3_k0", 64'(keylog[l0 % 256]), 64'hFE);
    check("s3_k1", 64'(keylog[(l0+1) % 256]), 64'hFF);
    check("s3_k2", 64'(keylog[(l0+2) % 256]), 64'h00);
    check("s3_k3", 64'(keylog[(l0+3) % 256]), 64'h01);

    // single key, then restart from DONE
    kick(8'h42, 8'h42, {56'h0, 8'h42 ^ 8'hA5});
    wait_done();
    check("s4_found", 64'(found), 64'd1);
    check("s4_trials", 64'(trials), 64'd1);
    check("s4_fkey", 64'(found_key), 64'h42);
    kick(8'h50, 8'h52, {56'h0, 8'h51 ^ 8'hA5});
    @(negedge clk);
    check("s4_clr_found", 64'(found), 64'd0);
    check("s4_load", 64'({busy, cnt_load}), 64'h3);
    wait_done();
    check("s4b_fkey", 64'(found_key), 64'h51);
    check("s4b_trials", 64'(trials), 64'd2);

    // abort during WAIT; the late result must be ignored
    kick(8'h10, 8'h20, NO_CT);
    wait_trials(2);
    @(posedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    check("ab_strobes", 64'({des_start, cnt_load, cnt_up}), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_trials", 64'(trials), 64'd0);
    s0 = n_start;
    repeat (8) @(negedge clk);
    check("ab_late_flags", 64'({found, exhausted}), 64'd0);
    check("ab_late_trials", 64'(trials), 64'd0);
    check("ab_no_launch", 64'(n_start - s0), 64'd0);

    // abort and start together from DONE
    kick(8'h42, 8'h42, {56'h0, 8'h42 ^ 8'hA5});
    wait_done();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; start_key = 8'h60; end_key = 8'h61;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("as_busy", 64'(busy), 64'd0);
    check("as_found", 64'(found), 64'd0);
    check("as_load", 64'(cnt_load), 64'd0);

    // asynchronous reset mid-search
    kick(8'h10, 8'h20, NO_CT);
    wait_trials(3);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_trials", 64'(trials), 64'd0);
    check("ar_strobes", 64'({des_start, cnt_load, cnt_up}), 64'd0);
    check("ar_keys", 64'({des_key, cnt_in}), 64'd0);
    @(negedge clk); rst = 1'b1;
    s0 = n_start;
    repeat (6) @(negedge clk);
    check("ar_idle", 64'({busy, cnt_load}), 64'd0);
    check("ar_no_launch", 64'(n_start - s0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
